// File: rtl/axi4_read_data_channel.sv
// AXI4-Lite master read data (R) channel: armed by the AR channel completion pulse,
// accepts one beat, and reports data/status or aborts after a configurable timeout.
module axi4_read_data_channel #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  STARTRD,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_err,
  output logic                  rd_timeout,
  output logic                  r_IDLE,
  output logic                  r_DONE
);

  // A zero-width counter is not legal, so a disabled timeout still keeps one (idle) bit.
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    rready_reg, rready_next;
  logic                    r_idle_reg, r_idle_next;
  logic                    r_done_reg, r_done_next;
  logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
  logic [1:0]              rd_resp_reg, rd_resp_next;
  logic                    rd_err_reg, rd_err_next;
  logic                    rd_timeout_reg, rd_timeout_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    handshake;

  assign handshake = RVALID && rready_reg;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg      <= IDLE;
      rready_reg     <= 1'b0;
      r_idle_reg     <= 1'b1;
      r_done_reg     <= 1'b0;
      rd_data_reg    <= '0;
      rd_resp_reg    <= 2'b00;
      rd_err_reg     <= 1'b0;
      rd_timeout_reg <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      rready_reg     <= rready_next;
      r_idle_reg     <= r_idle_next;
      r_done_reg     <= r_done_next;
      rd_data_reg    <= rd_data_next;
      rd_resp_reg    <= rd_resp_next;
      rd_err_reg     <= rd_err_next;
      rd_timeout_reg <= rd_timeout_next;
      cnt_reg        <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rready_next     = rready_reg;
    r_idle_next     = r_idle_reg;
    r_done_next     = r_done_reg;
    rd_data_next    = rd_data_reg;
    rd_resp_next    = rd_resp_reg;
    rd_err_next     = rd_err_reg;
    rd_timeout_next = rd_timeout_reg;
    cnt_next        = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (STARTRD) begin
          state_next      = WAIT;
          rready_next     = 1'b1;
          r_idle_next     = 1'b0;
          rd_timeout_next = 1'b0;
          cnt_next        = '0;
        end
      end
      WAIT: begin
        // The handshake is checked first so a beat landing on the threshold edge wins.
        if (handshake) begin
          state_next   = DONE;
          rready_next  = 1'b0;
          r_done_next  = 1'b1;
          rd_data_next = RDATA;
          rd_resp_next = RRESP;
          rd_err_next  = RRESP[1];
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
          state_next      = DONE;
          rready_next     = 1'b0;
          r_done_next     = 1'b1;
          rd_timeout_next = 1'b1;
        end else if (TIMEOUT_EN && (cnt_reg != CNT_MAX)) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next  = IDLE;
        r_done_next = 1'b0;
        r_idle_next = 1'b1;
      end
      default: begin
        state_next  = IDLE;
        rready_next = 1'b0;
        r_idle_next = 1'b1;
        r_done_next = 1'b0;
      end
    endcase
  end

  assign RREADY     = rready_reg;
  assign r_IDLE     = r_idle_reg;
  assign r_DONE     = r_done_reg;
  assign rd_data    = rd_data_reg;
  assign rd_resp    = rd_resp_reg;
  assign rd_err     = rd_err_reg;
  assign rd_timeout = rd_timeout_reg;

endmodule

// File: tb/tb_axi4_read_data_channel.sv
// Bench for axi4_read_data_channel: randomized reads scored against a
// transaction-level model of the expected handshake/timeout outcome.
module tb_axi4_read_data_channel;

  localparam int DW = 32;
  localparam int T  = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          STARTRD = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic [1:0]    RRESP = 2'b00;
  logic          RVALID = 1'b0;
  logic          RREADY;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          rd_err;
  logic          rd_timeout;
  logic          r_IDLE;
  logic          r_DONE;

  int checks = 0;
  int errors = 0;

  // Result the channel should be presenting after the most recent completed read.
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_resp = 2'b00;
  logic          m_err  = 1'b0;
  logic          m_to   = 1'b0;

  axi4_read_data_channel #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .STARTRD(STARTRD), .RDATA(RDATA),
    .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_err(rd_err), .rd_timeout(rd_timeout),
    .r_IDLE(r_IDLE), .r_DONE(r_DONE)
  );

  always #5 ACLK = ~ACLK;

  task automatic model_reset();
    m_data = '0;
    m_resp = 2'b00;
    m_err  = 1'b0;
    m_to   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (RREADY !== 1'b0 || r_IDLE !== 1'b1 || r_DONE !== 1'b0 || rd_data !== '0 ||
        rd_resp !== 2'b00 || rd_err !== 1'b0 || rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: rready=%b idle=%b done=%b data=%h resp=%b err=%b to=%b, required 0 1 0 0 00 0 0",
               name, RREADY, r_IDLE, r_DONE, rd_data, rd_resp, rd_err, rd_timeout);
    end
  endtask

  // delay d: RVALID is high at the d-th edge after the start edge (d outside 1..T never handshakes).
  // hold keeps RVALID high afterwards with junk data; spam pulses STARTRD while the read is busy.
  task automatic do_read(input string name, input int delay, input logic [DW-1:0] data,
                         input logic [1:0] resp, input bit hold, input bit spam);
    bit hs;
    int k;
    int rr_cnt, done_cnt, done_at, idle_bad;
    logic rv;
    hs = (delay >= 1) && (delay <= T);
    k  = hs ? delay : T;
    rr_cnt = 0; done_cnt = 0; done_at = 0; idle_bad = 0;

    @(posedge ACLK); #1;
    checks++;
    if (r_IDLE !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_before: r_IDLE=%b required 1", name, r_IDLE);
    end
    STARTRD = 1'b1;
    @(posedge ACLK); #1;
    STARTRD = 1'b0;
    checks++;
    if (r_IDLE !== 1'b0 || rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_armed: r_IDLE=%b rd_timeout=%b required 0 0", name, r_IDLE, rd_timeout);
    end

    for (int c = 1; c <= T + 4; c++) begin
      if (c > 1) begin
        @(posedge ACLK); #1;
      end
      if (RREADY === 1'b1) rr_cnt++;
      if (r_DONE === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (c >= k + 2 && (r_IDLE !== 1'b1 || RREADY !== 1'b0)) idle_bad++;
      rv = hold ? ((delay >= 1) && (c >= delay)) : (c == delay);
      RVALID  = rv;
      RDATA   = (c == delay) ? data : DW'($urandom);
      RRESP   = (c == delay) ? resp : 2'($urandom);
      STARTRD = spam && (c <= k + 1) && ($urandom_range(0, 1) == 1);
    end
    STARTRD = 1'b0;
    RVALID  = 1'b0;

    if (hs) begin
      m_data = data;
      m_resp = resp;
      m_err  = resp[1];
      m_to   = 1'b0;
    end else begin
      m_to = 1'b1;
    end

    checks++;
    if (rr_cnt != k) begin
      errors++;
      $display("FAIL %s_rready_cycles: got %0d required %0d", name, rr_cnt, k);
    end
    checks++;
    if (done_cnt != 1 || done_at != k + 1) begin
      errors++;
      $display("FAIL %s_done_pulse: count=%0d at=%0d required count=1 at=%0d", name, done_cnt, done_at, k + 1);
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL %s_idle_after: %0d cycles not idle, required 0", name, idle_bad);
    end
    checks++;
    if (rd_data !== m_data || rd_resp !== m_resp || rd_err !== m_err || rd_timeout !== m_to) begin
      errors++;
      $display("FAIL %s_result: data=%h resp=%b err=%b to=%b required data=%h resp=%b err=%b to=%b",
               name, rd_data, rd_resp, rd_err, rd_timeout, m_data, m_resp, m_err, m_to);
    end
    $display("read %s: delay=%0d hold=%0d spam=%0d -> data=%h resp=%b err=%b timeout=%b",
             name, delay, hold, spam, rd_data, rd_resp, rd_err, rd_timeout);
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      STARTRD = 1'(($urandom));
      RVALID  = 1'($urandom);
      RDATA   = DW'($urandom);
      RRESP   = 2'($urandom);
      check_reset_outputs("reset_hold");
    end
    STARTRD = 1'b0;
    RVALID  = 1'b0;
    ARESETN = 1'b1;
    model_reset();
    @(posedge ACLK); #1;
    check_reset_outputs("reset_release");
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_basic();
    do_read("basic", 3, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_error();
    do_read("slverr", $urandom_range(1, 4), 32'h12345678, 2'b10, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_read("timeout_hold", T + 1, 32'hCAFEF00D, 2'b00, 1'b1, 1'b0);
    do_read("timeout_late", T + 2, 32'h0BADF00D, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic test_boundary();
    do_read("boundary", T, 32'hA5A55A5A, 2'b01, 1'b0, 1'b0);
    do_read("boundary_hold", T, 32'h13572468, 2'b11, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_read("start_spam", 5, 32'h0F0F1234, 2'b00, 1'b0, 1'b1);
    do_read("start_spam_to", 0, 32'h0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge ACLK); #1;
    STARTRD = 1'b1;
    @(posedge ACLK); #1;
    STARTRD = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if (RREADY !== 1'b1) begin
      errors++;
      $display("FAIL midwait_rready_before: RREADY=%b required 1", RREADY);
    end
    ARESETN = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midwait_async");
    RVALID = 1'b1;
    RDATA  = 32'hFFFF0000;
    repeat (2) @(posedge ACLK);
    #1;
    check_reset_outputs("midwait_held");
    RVALID  = 1'b0;
    ARESETN = 1'b1;
    $display("reset mid-wait: outputs dropped asynchronously");
    do_read("after_reset", 2, 32'h55AA33CC, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      do_read($sformatf("rand%0d", i), $urandom_range(1, T + 3), DW'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_timeout();
    test_boundary();
    test_start_ignored();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
